// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - request/result bundle between the control FSM and alu_seq
interface alu_seq_if #(
    parameter int WIDTH = 16
);
    logic             bgn;
    logic [5:0]       opcode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] acc1;
    logic [WIDTH-1:0] acc2;
    logic             zero;
    logic             negative;
    logic             carry;
    logic             overflow;
    logic             busy;
    logic             rdy;

    modport master (
        output bgn, opcode, A, B,
        input  acc1, acc2, zero, negative, carry, overflow, busy, rdy
    );

    modport slave (
        input  bgn, opcode, A, B,
        output acc1, acc2, zero, negative, carry, overflow, busy, rdy
    );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle ALU: single-cycle logic/arith, iterative shift-add MUL and restoring DIV
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);
    localparam int               CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] W_VAL     = WIDTH'(WIDTH);

    localparam logic [5:0] OP_NOP = 6'd0;
    localparam logic [5:0] OP_ADD = 6'd1;
    localparam logic [5:0] OP_SUB = 6'd2;
    localparam logic [5:0] OP_SHL = 6'd3;
    localparam logic [5:0] OP_SHR = 6'd4;
    localparam logic [5:0] OP_AND = 6'd5;
    localparam logic [5:0] OP_OR  = 6'd6;
    localparam logic [5:0] OP_XOR = 6'd7;
    localparam logic [5:0] OP_MUL = 6'd8;
    localparam logic [5:0] OP_DIV = 6'd9;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    state_t           state_q;
    logic [5:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] acc1_q, acc2_q;
    logic             zero_q, neg_q, carry_q, ovf_q, busy_q, rdy_q;

    logic [WIDTH:0]   add_w, sub_w, shl_w, shr_w;
    logic [WIDTH-1:0] alu_res_d;
    logic             alu_c_d, alu_v_d, alu_wr_d;

    always_comb begin
        add_w     = {1'b0, a_q} + {1'b0, b_q};
        sub_w     = {1'b0, a_q} - {1'b0, b_q};
        // The extra bit catches the last bit shifted out; amounts past WIDTH clear everything.
        shl_w     = (b_q <= W_VAL) ? ({1'b0, a_q} << b_q) : '0;
        shr_w     = (b_q <= W_VAL) ? ({a_q, 1'b0} >> b_q) : '0;
        alu_wr_d  = 1'b1;
        alu_res_d = '0;
        alu_c_d   = 1'b0;
        alu_v_d   = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res_d = add_w[WIDTH-1:0];
                alu_c_d   = add_w[WIDTH];
                alu_v_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_w[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res_d = sub_w[WIDTH-1:0];
                alu_c_d   = sub_w[WIDTH];
                alu_v_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_w[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SHL: begin
                alu_res_d = shl_w[WIDTH-1:0];
                alu_c_d   = shl_w[WIDTH];
            end
            OP_SHR: begin
                alu_res_d = shr_w[WIDTH:1];
                alu_c_d   = shr_w[0];
            end
            OP_AND:  alu_res_d = a_q & b_q;
            OP_OR:   alu_res_d = a_q | b_q;
            OP_XOR:  alu_res_d = a_q ^ b_q;
            OP_NOP:  alu_wr_d  = 1'b0;
            default: alu_wr_d  = 1'b0;
        endcase
    end

    // One iteration of the MUL/DIV loop over the {hi_q, lo_q} working pair.
    logic [WIDTH:0]   mul_sum, rem_s, rem_sub;
    logic [WIDTH-1:0] step_hi_d, step_lo_d;

    always_comb begin
        mul_sum = lo_q[0] ? ({1'b0, hi_q} + {1'b0, a_q}) : {1'b0, hi_q};
        rem_s   = {hi_q, lo_q[WIDTH-1]};
        rem_sub = rem_s - {1'b0, b_q};
        if (op_q == OP_MUL) begin
            step_hi_d = mul_sum[WIDTH:1];
            step_lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end else begin
            step_hi_d = rem_sub[WIDTH] ? rem_s[WIDTH-1:0] : rem_sub[WIDTH-1:0];
            step_lo_d = {lo_q[WIDTH-2:0], ~rem_sub[WIDTH]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            acc1_q  <= '0;
            acc2_q  <= '0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    rdy_q <= 1'b0;
                    if (bus.bgn) begin
                        op_q    <= bus.opcode;
                        a_q     <= bus.A;
                        b_q     <= bus.B;
                        hi_q    <= '0;
                        lo_q    <= (bus.opcode == OP_MUL) ? bus.B : bus.A;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (op_q == OP_MUL || (op_q == OP_DIV && b_q != '0)) begin
                        hi_q  <= step_hi_d;
                        lo_q  <= step_lo_d;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == LAST_ITER) begin
                            acc1_q  <= step_lo_d;
                            acc2_q  <= step_hi_d;
                            zero_q  <= (step_lo_d == '0) && (step_hi_d == '0);
                            neg_q   <= (op_q == OP_MUL) ? step_hi_d[WIDTH-1] : step_lo_d[WIDTH-1];
                            carry_q <= 1'b0;
                            ovf_q   <= (op_q == OP_MUL) && (step_hi_d != '0);
                            state_q <= S_DONE;
                        end
                    end else if (op_q == OP_DIV) begin
                        acc1_q  <= '1;
                        acc2_q  <= a_q;
                        zero_q  <= 1'b0;
                        neg_q   <= 1'b1;
                        carry_q <= 1'b0;
                        ovf_q   <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        if (alu_wr_d) begin
                            acc1_q  <= alu_res_d;
                            acc2_q  <= '0;
                            zero_q  <= (alu_res_d == '0);
                            neg_q   <= alu_res_d[WIDTH-1];
                            carry_q <= alu_c_d;
                            ovf_q   <= alu_v_d;
                        end
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    rdy_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.acc1     = acc1_q;
    assign bus.acc2     = acc2_q;
    assign bus.zero     = zero_q;
    assign bus.negative = neg_q;
    assign bus.carry    = carry_q;
    assign bus.overflow = ovf_q;
    assign bus.busy     = busy_q;
    assign bus.rdy      = rdy_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized and directed bench for alu_seq against an arithmetic reference model
module tb_alu_seq;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W)) bus ();
    alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int failures = 0;
    // {acc1, acc2, zero, negative, carry, overflow} the model expects to be held now
    logic [35:0] exp_vec = '0;

    function automatic int model(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b);
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint r;
        int sa = $signed(a);
        int sb = $signed(b);
        int sr;
        logic [15:0] r1 = '0;
        logic [15:0] r2 = '0;
        bit c = 0, v = 0, wr = 1;
        case (op)
            1: begin r = ua + ub; r1 = 16'(r % 65536); c = r > 65535;
                     sr = sa + sb; v = (sr > 32767) || (sr < -32768); end
            2: begin r1 = 16'((ua - ub + 65536) % 65536); c = ua < ub;
                     sr = sa - sb; v = (sr > 32767) || (sr < -32768); end
            3: if (ub == 0) r1 = a;
               else if (ub <= 16) begin r = ua << ub; r1 = 16'(r % 65536); c = ((r >> 16) & 1) != 0; end
            4: if (ub == 0) r1 = a;
               else if (ub <= 16) begin r1 = 16'(ua >> ub); c = ((ua >> (ub - 1)) & 1) != 0; end
            5: r1 = a & b;
            6: r1 = a | b;
            7: r1 = a ^ b;
            8: begin r = ua * ub; r1 = 16'(r % 65536); r2 = 16'(r / 65536); v = r2 != 0; end
            9: if (ub == 0) begin r1 = 16'hFFFF; r2 = a; v = 1; end
               else begin r1 = 16'(ua / ub); r2 = 16'(ua % ub); end
            default: wr = 0;
        endcase
        if (wr) exp_vec = {r1, r2, (r1 == 0 && r2 == 0), (op == 8) ? r2[15] : r1[15], c, v};
        return (op == 8 || (op == 9 && b != 0)) ? W + 1 : 2;
    endfunction

    task automatic do_op(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b, input bit noise,
                         output int lat, output logic [35:0] obs, output bit busy_ok, output bit pulse_ok);
        busy_ok = 1; pulse_ok = 1; lat = -1;
        @(negedge clk);
        bus.opcode = op; bus.A = a; bus.B = b; bus.bgn = 1'b1;
        @(posedge clk); #1;
        bus.bgn = 1'b0; bus.A = 16'($urandom); bus.B = 16'($urandom); bus.opcode = 6'($urandom);
        if (!bus.busy) busy_ok = 0;
        for (int n = 1; n <= 60; n++) begin
            bus.bgn = (noise && n < 8) ? n[0] : 1'b0;
            @(posedge clk); #1;
            if (bus.rdy) begin lat = n; break; end
            if (!bus.busy) busy_ok = 0;
        end
        bus.bgn = 1'b0;
        obs = {bus.acc1, bus.acc2, bus.zero, bus.negative, bus.carry, bus.overflow};
        if (bus.busy) busy_ok = 0;
        @(posedge clk); #1;
        if (bus.rdy) pulse_ok = 0;
    endtask

    task automatic test_reset;
        logic [37:0] o;
        o = {bus.acc1, bus.acc2, bus.zero, bus.negative, bus.carry, bus.overflow, bus.busy, bus.rdy};
        checks++;
        if (o !== '0) begin failures++; $display("FAIL reset_state got=%h exp=0", o); end
    endtask

    task automatic test_add;
        int lat, el; logic [35:0] obs; bit bok, pok;
        el = model(6'd1, 16'hFFFF, 16'h0001);
        do_op(6'd1, 16'hFFFF, 16'h0001, 0, lat, obs, bok, pok);
        checks++;
        if (obs !== {16'h0000, 16'h0000, 4'b1010}) begin failures++; $display("FAIL add_wrap got=%h exp=%h", obs, {32'h0, 4'b1010}); end
        checks++;
        if (lat !== 2 || !bok || !pok) begin failures++; $display("FAIL add_latency got=%0d busy_ok=%0d pulse_ok=%0d exp=2", lat, bok, pok); end
    endtask

    task automatic test_sub;
        int lat, el; logic [35:0] obs; bit bok, pok;
        el = model(6'd2, 16'h8000, 16'h0001);
        do_op(6'd2, 16'h8000, 16'h0001, 0, lat, obs, bok, pok);
        checks++;
        if (obs !== {16'h7FFF, 16'h0000, 4'b0001}) begin failures++; $display("FAIL sub_ovf got=%h exp=%h", obs, {16'h7FFF, 16'h0, 4'b0001}); end
        el = model(6'd2, 16'd3, 16'd5);
        do_op(6'd2, 16'd3, 16'd5, 0, lat, obs, bok, pok);
        checks++;
        if (obs !== {16'hFFFE, 16'h0000, 4'b0110}) begin failures++; $display("FAIL sub_borrow got=%h exp=%h", obs, {16'hFFFE, 16'h0, 4'b0110}); end
    endtask

    task automatic test_mul;
        int lat, el; logic [35:0] obs; bit bok, pok;
        logic [15:0] a, b;
        el = model(6'd8, 16'h1234, 16'h0100);
        do_op(6'd8, 16'h1234, 16'h0100, 1, lat, obs, bok, pok);
        checks++;
        if (obs !== {16'h3400, 16'h0012, 4'b0001}) begin failures++; $display("FAIL mul_dir got=%h exp=%h", obs, {16'h3400, 16'h0012, 4'b0001}); end
        checks++;
        if (lat !== 17 || !bok || !pok) begin failures++; $display("FAIL mul_latency got=%0d busy_ok=%0d pulse_ok=%0d exp=17", lat, bok, pok); end
        for (int i = 0; i < 6; i++) begin
            a = 16'($urandom); b = (i == 0) ? 16'h0 : 16'($urandom >> (i * 2));
            el = model(6'd8, a, b);
            do_op(6'd8, a, b, i[0], lat, obs, bok, pok);
            checks++;
            if (obs !== exp_vec || lat !== el || !bok || !pok) begin
                failures++; $display("FAIL mul_rand a=%h b=%h got=%h/%0d exp=%h/%0d", a, b, obs, lat, exp_vec, el);
            end
        end
    endtask

    task automatic test_div;
        int lat, el; logic [35:0] obs; bit bok, pok;
        logic [15:0] a, b;
        el = model(6'd9, 16'd100, 16'd7);
        do_op(6'd9, 16'd100, 16'd7, 0, lat, obs, bok, pok);
        checks++;
        if (obs !== {16'd14, 16'd2, 4'b0000} || lat !== 17) begin failures++; $display("FAIL div_dir got=%h/%0d exp=%h/17", obs, lat, {16'd14, 16'd2, 4'b0}); end
        el = model(6'd9, 16'd5, 16'd0);
        do_op(6'd9, 16'd5, 16'd0, 0, lat, obs, bok, pok);
        checks++;
        if (obs !== {16'hFFFF, 16'd5, 4'b0101} || lat !== 2) begin failures++; $display("FAIL div_zero got=%h/%0d exp=%h/2", obs, lat, {16'hFFFF, 16'd5, 4'b0101}); end
        for (int i = 0; i < 6; i++) begin
            a = 16'($urandom); b = 16'($urandom >> (i * 2 + 4));
            el = model(6'd9, a, b);
            do_op(6'd9, a, b, 0, lat, obs, bok, pok);
            checks++;
            if (obs !== exp_vec || lat !== el || !bok || !pok) begin
                failures++; $display("FAIL div_rand a=%h b=%h got=%h/%0d exp=%h/%0d", a, b, obs, lat, exp_vec, el);
            end
        end
    endtask

    task automatic test_shift;
        int lat, el; logic [35:0] obs; bit bok, pok;
        logic [5:0]  ops [3] = '{6'd3, 6'd3, 6'd4};
        logic [15:0] bs  [3] = '{16'd1, 16'd16, 16'd20};
        logic [35:0] want[3] = '{{16'h0002, 16'h0, 4'b0010}, {16'h0, 16'h0, 4'b1010}, {16'h0, 16'h0, 4'b1000}};
        logic [15:0] a, b;
        for (int i = 0; i < 3; i++) begin
            el = model(ops[i], 16'h8001, bs[i]);
            do_op(ops[i], 16'h8001, bs[i], 0, lat, obs, bok, pok);
            checks++;
            if (obs !== want[i]) begin failures++; $display("FAIL shift_dir%0d got=%h exp=%h", i, obs, want[i]); end
        end
        for (int i = 0; i < 10; i++) begin
            a = 16'($urandom); b = 16'($urandom_range(0, 20));
            el = model(6'(3 + i % 2), a, b);
            do_op(6'(3 + i % 2), a, b, 0, lat, obs, bok, pok);
            checks++;
            if (obs !== exp_vec || lat !== el) begin failures++; $display("FAIL shift_rand a=%h b=%0d got=%h exp=%h", a, b, obs, exp_vec); end
        end
    endtask

    task automatic test_back_to_back;
        int lat, el; logic [35:0] obs; bit bok, pok;
        logic [5:0] op; logic [15:0] a, b;
        for (int i = 0; i < 40; i++) begin
            op = 6'($urandom_range(0, 12)); a = 16'($urandom); b = 16'($urandom);
            if (op == 9 && i % 5 == 0) b = '0;
            el = model(op, a, b);
            do_op(op, a, b, 0, lat, obs, bok, pok);
            checks++;
            if (obs !== exp_vec || lat !== el || !bok || !pok) begin
                failures++; $display("FAIL b2b op=%0d a=%h b=%h got=%h/%0d exp=%h/%0d", op, a, b, obs, lat, exp_vec, el);
            end
        end
    endtask

    task automatic test_reset_mid_op;
        int lat, el; logic [35:0] obs; bit bok, pok, seen;
        logic [37:0] o;
        @(negedge clk);
        bus.opcode = 6'd8; bus.A = 16'hFFFF; bus.B = 16'hFFFF; bus.bgn = 1'b1;
        @(posedge clk); #1; bus.bgn = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        o = {bus.acc1, bus.acc2, bus.zero, bus.negative, bus.carry, bus.overflow, bus.busy, bus.rdy};
        checks++;
        if (o !== '0) begin failures++; $display("FAIL reset_abort got=%h exp=0", o); end
        exp_vec = '0;
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        seen = 0;
        repeat (25) begin @(posedge clk); #1; if (bus.rdy || bus.busy) seen = 1; end
        checks++;
        if (seen) begin failures++; $display("FAIL reset_no_rdy got=1 exp=0"); end
        el = model(6'd1, 16'd2, 16'd3);
        do_op(6'd1, 16'd2, 16'd3, 0, lat, obs, bok, pok);
        checks++;
        if (obs !== {16'd5, 16'd0, 4'b0000} || lat !== 2) begin failures++; $display("FAIL reset_then_add got=%h/%0d exp=%h/2", obs, lat, {16'd5, 20'd0}); end
    endtask

    initial begin
        rst_n = 1'b0; bus.bgn = 1'b0; bus.opcode = '0; bus.A = '0; bus.B = '0;
        repeat (3) @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        @(negedge clk);
        test_reset;
        test_add;
        test_sub;
        test_mul;
        test_div;
        test_shift;
        test_back_to_back;
        test_reset_mid_op;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
